// File: rtl/gate_seq_ctrl_if.sv
// Handshake, gate-drive and result signals of the gate sequencing controller.
// The controller connects through the slave modport and the requester through master.
interface gate_seq_ctrl_if;
  logic       i_start;
  logic       i_abort;
  logic       i_x;
  logic [3:0] i_expect;
  logic       o_a;
  logic       o_b;
  logic       o_busy;
  logic       o_done;
  logic [3:0] o_table;
  logic       o_match;

  modport slave (
    input  i_start, i_abort, i_x, i_expect,
    output o_a, o_b, o_busy, o_done, o_table, o_match
  );

  modport master (
    output i_start, i_abort, i_x, i_expect,
    input  o_a, o_b, o_busy, o_done, o_table, o_match
  );
endinterface

// File: rtl/gate_seq_ctrl.sv
// Steps a two-input gate through (a,b) = 00,10,01,11 and captures its truth table.
// Optional GATE_SEQ_CHECK_EN compares the captured table against i_expect.
module gate_seq_ctrl #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  gate_seq_ctrl_if.slave  bus
);

  localparam int unsigned   CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    idx;
  logic [CW-1:0] hold_cnt;
  logic [3:0]    table_q;
  logic          start_ok;
  logic          step_end;

  // Abort beats start when both arrive in IDLE.
  assign start_ok = bus.i_start & ~bus.i_abort;
  assign step_end = (hold_cnt == HOLD_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = DRIVE;
      DRIVE: begin
        if (bus.i_abort)                   state_nxt = IDLE;
        else if (step_end && idx == 2'd3)  state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx      <= '0;
      hold_cnt <= '0;
      table_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            idx      <= '0;
            hold_cnt <= '0;
            table_q  <= '0;
          end
        end
        DRIVE: begin
          if (bus.i_abort) begin
            idx      <= '0;
            hold_cnt <= '0;
            table_q  <= '0;
          end else if (step_end) begin
            // idx rolls over to 0 after the last step while the FSM leaves DRIVE
            table_q[idx] <= bus.i_x;
            hold_cnt     <= '0;
            idx          <= idx + 2'd1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.o_a    = 1'b0;
    bus.o_b    = 1'b0;
    bus.o_busy = 1'b0;
    bus.o_done = 1'b0;
    case (state)
      DRIVE: begin
        bus.o_a    = idx[0];
        bus.o_b    = idx[1];
        bus.o_busy = 1'b1;
      end
      DONE:    bus.o_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.o_table = table_q;

`ifdef GATE_SEQ_CHECK_EN
  logic match_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                          match_q <= 1'b0;
    else if (state == IDLE && start_ok) match_q <= 1'b0;
    else if (state == DONE)             match_q <= (table_q == bus.i_expect);
  end

  assign bus.o_match = match_q;
`else
  assign bus.o_match = 1'b0;
`endif

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Directed bench for gate_seq_ctrl: one instance with HOLD_CYCLES=2, one with HOLD_CYCLES=1,
// each wrapped around an AND/OR gate model selected by gate_or.
module tb_gate_seq_ctrl;

`ifdef GATE_SEQ_CHECK_EN
  localparam logic MATCH_EN = 1'b1;
`else
  localparam logic MATCH_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic gate_or = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  gate_seq_ctrl_if bus2 ();
  gate_seq_ctrl_if bus1 ();

  assign bus2.i_x = gate_or ? (bus2.o_a | bus2.o_b) : (bus2.o_a & bus2.o_b);
  assign bus1.i_x = gate_or ? (bus1.o_a | bus1.o_b) : (bus1.o_a & bus1.o_b);

  gate_seq_ctrl #(.HOLD_CYCLES(2)) u_h2 (.i_clk(clk), .i_rst(rst), .bus(bus2.slave));
  gate_seq_ctrl #(.HOLD_CYCLES(1)) u_h1 (.i_clk(clk), .i_rst(rst), .bus(bus1.slave));

  // {busy, done, a, b, table[3:0], match}
  logic [8:0] out2;
  logic [8:0] out1;
  assign out2 = {bus2.o_busy, bus2.o_done, bus2.o_a, bus2.o_b, bus2.o_table, bus2.o_match};
  assign out1 = {bus1.o_busy, bus1.o_done, bus1.o_a, bus1.o_b, bus1.o_table, bus1.o_match};

  function automatic logic [8:0] pk(input logic busy, input logic done, input logic a,
                                    input logic b, input logic [3:0] tbl, input logic match);
    return {busy, done, a, b, tbl, match};
  endfunction

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] idx;
    logic [3:0] or_tbl [4];
    or_tbl = '{4'b0000, 4'b0000, 4'b0010, 4'b0110};

    bus2.i_start = 1'b0; bus2.i_abort = 1'b0; bus2.i_expect = '0;
    bus1.i_start = 1'b0; bus1.i_abort = 1'b0; bus1.i_expect = '0;

    // reset state
    #12;
    chk("reset_h2", out2, '0);
    chk("reset_h1", out1, '0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // AND gate, HOLD_CYCLES=2
    gate_or = 1'b0;
    bus2.i_start = 1'b1;
    tick();
    bus2.i_start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = 2'((k - 1) / 2);
      chk($sformatf("and_h2_c%0d", k), out2, pk(1'b1, 1'b0, idx[0], idx[1], 4'b0000, 1'b0));
      tick();
    end
    chk("and_h2_done", out2, pk(1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0));
    tick();
    chk("and_h2_hold", out2, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0));

    // OR gate, HOLD_CYCLES=1, matching expectation
    gate_or = 1'b1;
    bus1.i_expect = 4'b1110;
    bus1.i_start = 1'b1;
    tick();
    bus1.i_start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = 2'(k - 1);
      chk($sformatf("or_h1_c%0d", k), out1, pk(1'b1, 1'b0, idx[0], idx[1], or_tbl[k-1], 1'b0));
      tick();
    end
    chk("or_h1_done", out1, pk(1'b0, 1'b1, 1'b0, 1'b0, 4'b1110, 1'b0));
    tick();
    chk("or_h1_match", out1, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'b1110, MATCH_EN));

    // OR gate, HOLD_CYCLES=1, mismatching expectation
    bus1.i_expect = 4'b1000;
    bus1.i_start = 1'b1;
    tick();
    bus1.i_start = 1'b0;
    chk("or_h1_restart", out1, pk(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    repeat (4) tick();
    chk("or_h1_done2", out1, pk(1'b0, 1'b1, 1'b0, 1'b0, 4'b1110, 1'b0));
    tick();
    chk("or_h1_nomatch", out1, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'b1110, 1'b0));

    // start held high: one run per 6 cycles
    bus1.i_start = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      chk($sformatf("b2b_c%0d", k), {7'b0, bus1.o_busy, bus1.o_done},
          {7'b0, ((k % 6) >= 1 && (k % 6) <= 4), ((k % 6) == 5)});
      if (k == 24) bus1.i_start = 1'b0;
    end
    tick();
    chk("b2b_stop", {7'b0, bus1.o_busy, bus1.o_done}, '0);

    // abort during step idx=2
    bus2.i_start = 1'b1;
    tick();
    bus2.i_start = 1'b0;
    repeat (4) tick();
    chk("abort_pre", out2, pk(1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0));
    bus2.i_abort = 1'b1;
    tick();
    bus2.i_abort = 1'b0;
    chk("abort_idle", out2, '0);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("abort_quiet_%0d", k), {7'b0, bus2.o_busy, bus2.o_done}, '0);
    end

    // start and abort together in IDLE
    bus2.i_start = 1'b1;
    bus2.i_abort = 1'b1;
    tick();
    chk("start_abort_1", out2, '0);
    tick();
    chk("start_abort_2", out2, '0);
    bus2.i_start = 1'b0;
    bus2.i_abort = 1'b0;

    // asynchronous reset mid-DRIVE
    bus2.i_start = 1'b1;
    tick();
    bus2.i_start = 1'b0;
    repeat (6) tick();
    chk("rst_pre", out2, pk(1'b1, 1'b0, 1'b1, 1'b1, 4'b0110, 1'b0));
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_h2", out2, '0);
    chk("rst_async_h1", out1, '0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // fresh run after reset
    gate_or = 1'b0;
    bus2.i_start = 1'b1;
    tick();
    bus2.i_start = 1'b0;
    chk("post_rst_c1", out2, pk(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    repeat (8) tick();
    chk("post_rst_done", out2, pk(1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
